// File: rtl/fc_argmax.sv
// Running argmax over a frame of BATCH float32 class scores; emits winning index and score.
// Optional FC_ARGMAX_TIMEOUT_EN adds an idle-gap watchdog that drops partial frames and pulses err.
module fc_argmax #(
  parameter int unsigned BIT     = 32,
  parameter int unsigned BATCH   = 7,
  parameter int unsigned IDX_W   = 3,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic [BIT-1:0]   data_in,
  output logic [IDX_W-1:0] class_out,
  output logic [BIT-1:0]   max_out,
  output logic             done,
  output logic             busy
`ifdef FC_ARGMAX_TIMEOUT_EN
  ,
  output logic             err
`endif
);

  localparam int unsigned EXP_W = 8;
  localparam int unsigned MAN_W = 23;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BATCH - 1);

  if (BIT != 32 || BATCH < 2 || (1 << IDX_W) < BATCH || TIMEOUT < 1) begin : g_bad_param
    $error("fc_argmax: unsupported parameter set");
  end

  typedef enum logic {
    S_IDLE,
    S_ACCUM
  } state_t;

  // Float32 strict greater-than; NaN ranks below every value, +0 equals -0.
  function automatic logic f_gt(input logic [BIT-1:0] a, input logic [BIT-1:0] b);
    logic a_nan;
    logic b_nan;
    a_nan = (a[BIT-2 -: EXP_W] == '1) && (a[MAN_W-1:0] != '0);
    b_nan = (b[BIT-2 -: EXP_W] == '1) && (b[MAN_W-1:0] != '0);
    if (a_nan) return 1'b0;
    if (b_nan) return 1'b1;
    if (a[BIT-1] != b[BIT-1])
      return !a[BIT-1] && ((a[BIT-2:0] != '0) || (b[BIT-2:0] != '0));
    if (!a[BIT-1]) return a[BIT-2:0] > b[BIT-2:0];
    return a[BIT-2:0] < b[BIT-2:0];
  endfunction

  state_t           r_state,     w_state_nx;
  logic [IDX_W-1:0] r_cnt,       w_cnt_nx;
  logic [BIT-1:0]   r_best_val,  w_best_val_nx;
  logic [IDX_W-1:0] r_best_idx,  w_best_idx_nx;
  logic [IDX_W-1:0] r_class_out, w_class_out_nx;
  logic [BIT-1:0]   r_max_out,   w_max_out_nx;
  logic             r_done,      w_done_nx;
  logic             w_gt;

`ifdef FC_ARGMAX_TIMEOUT_EN
  localparam int unsigned GAP_W = $clog2(TIMEOUT + 1);
  logic [GAP_W-1:0] r_gap, w_gap_nx;
  logic             r_err, w_err_nx;
  assign err = r_err;
`endif

  assign w_gt      = f_gt(data_in, r_best_val);
  assign class_out = r_class_out;
  assign max_out   = r_max_out;
  assign done      = r_done;
  assign busy      = (r_state == S_ACCUM);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_best_val  <= '0;
      r_best_idx  <= '0;
      r_class_out <= '0;
      r_max_out   <= '0;
      r_done      <= 1'b0;
`ifdef FC_ARGMAX_TIMEOUT_EN
      r_gap       <= '0;
      r_err       <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nx;
      r_cnt       <= w_cnt_nx;
      r_best_val  <= w_best_val_nx;
      r_best_idx  <= w_best_idx_nx;
      r_class_out <= w_class_out_nx;
      r_max_out   <= w_max_out_nx;
      r_done      <= w_done_nx;
`ifdef FC_ARGMAX_TIMEOUT_EN
      r_gap       <= w_gap_nx;
      r_err       <= w_err_nx;
`endif
    end
  end

  // Next-state and output logic.
  always_comb begin
    w_state_nx     = r_state;
    w_cnt_nx       = r_cnt;
    w_best_val_nx  = r_best_val;
    w_best_idx_nx  = r_best_idx;
    w_class_out_nx = r_class_out;
    w_max_out_nx   = r_max_out;
    w_done_nx      = 1'b0;
`ifdef FC_ARGMAX_TIMEOUT_EN
    w_gap_nx       = '0;
    w_err_nx       = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (valid_in) begin
          w_best_val_nx = data_in;
          w_best_idx_nx = '0;
          w_cnt_nx      = IDX_W'(1);
          w_state_nx    = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (valid_in) begin
          if (w_gt) begin
            w_best_val_nx = data_in;
            w_best_idx_nx = r_cnt;
          end
          if (r_cnt == LAST_IDX) begin
            w_class_out_nx = w_gt ? r_cnt : r_best_idx;
            w_max_out_nx   = w_gt ? data_in : r_best_val;
            w_done_nx      = 1'b1;
            w_cnt_nx       = '0;
            w_state_nx     = S_IDLE;
          end else begin
            w_cnt_nx = r_cnt + IDX_W'(1);
          end
        end else begin
`ifdef FC_ARGMAX_TIMEOUT_EN
          if (r_gap == GAP_W'(TIMEOUT - 1)) begin
            w_err_nx   = 1'b1;
            w_cnt_nx   = '0;
            w_state_nx = S_IDLE;
          end else begin
            w_gap_nx = r_gap + GAP_W'(1);
          end
`endif
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fc_argmax.sv
// Self-checking bench for fc_argmax: directed vectors, random frames, back-to-back and reset cases.
module tb_fc_argmax;

  typedef logic [31:0] frame_t [7];

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [31:0] data_in;
  logic [2:0]  class_out;
  logic [31:0] max_out;
  logic        done;
  logic        busy;
`ifdef FC_ARGMAX_TIMEOUT_EN
  logic        err;
`endif

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [2:0]  exp_class;
  logic [31:0] exp_max;

  fc_argmax #(.BIT(32), .BATCH(7), .IDX_W(3), .TIMEOUT(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .class_out (class_out),
    .max_out   (max_out),
    .done      (done),
    .busy      (busy)
`ifdef FC_ARGMAX_TIMEOUT_EN
    ,
    .err       (err)
`endif
  );

  always #5 clk = ~clk;

  // Total-order key of a float32 score; NaN sits below -Inf, both zeros map to 0.
  function automatic longint score_key(input logic [31:0] x);
    if (x[30:23] == 8'hFF && x[22:0] != 23'd0) return -(longint'(1) <<< 40);
    if (x[31]) return -longint'(x[30:0]);
    return longint'(x[30:0]);
  endfunction

  function automatic int ref_argmax(input frame_t s);
    int best = 0;
    for (int i = 1; i < 7; i++)
      if (score_key(s[i]) > score_key(s[best])) best = i;
    return best;
  endfunction

  // Drive one frame with random gaps up to max_gap; check hold behaviour and the done cycle.
  task automatic run_frame(input string name, input frame_t s, input int max_gap);
    int          ei;
    logic [31:0] em;
    ei = ref_argmax(s);
    em = s[ei];
    for (int i = 0; i < 7; i++) begin
      int g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      for (int k = 0; k < g; k++) begin
        valid_in = 1'b0;
        @(posedge clk); #1;
        n_chk++;
        if (done !== 1'b0 || class_out !== exp_class || max_out !== exp_max) begin
          $display("FAIL %s gap_hold: done=%b class=%0d max=%h required done=0 class=%0d max=%h",
                   name, done, class_out, max_out, exp_class, exp_max);
          n_fail++;
        end
      end
      valid_in = 1'b1;
      data_in  = s[i];
      @(posedge clk); #1;
      valid_in = 1'b0;
      if (i < 6) begin
        n_chk++;
        if (done !== 1'b0 || busy !== 1'b1 || class_out !== exp_class || max_out !== exp_max) begin
          $display("FAIL %s mid_frame beat%0d: done=%b busy=%b class=%0d max=%h required done=0 busy=1 class=%0d max=%h",
                   name, i, done, busy, class_out, max_out, exp_class, exp_max);
          n_fail++;
        end
      end
    end
    exp_class = 3'(ei);
    exp_max   = em;
    n_chk++;
    if (done !== 1'b1 || busy !== 1'b0 || class_out !== exp_class || max_out !== exp_max) begin
      $display("FAIL %s result: done=%b busy=%b class=%0d max=%h required done=1 busy=0 class=%0d max=%h",
               name, done, busy, class_out, max_out, exp_class, exp_max);
      n_fail++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; valid_in = 1'b0; data_in = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_class = '0; exp_max = '0;
    n_chk++;
    if (class_out !== 3'd0 || max_out !== 32'd0 || done !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL reset_values: class=%0d max=%h done=%b busy=%b required all zero",
               class_out, max_out, done, busy);
      n_fail++;
    end
`ifdef FC_ARGMAX_TIMEOUT_EN
    n_chk++;
    if (err !== 1'b0) begin
      $display("FAIL reset_err: err=%b required 0", err);
      n_fail++;
    end
`endif
  endtask

  task automatic test_basic();
    frame_t s = '{32'h3F000000, 32'h3F800000, 32'h40400000, 32'h40000000,
                  32'h00000000, 32'h3F000000, 32'h3F800000};
    run_frame("basic", s, 0);
    n_chk++;
    if (class_out !== 3'd2 || max_out !== 32'h40400000) begin
      $display("FAIL basic_const: class=%0d max=%h required class=2 max=40400000", class_out, max_out);
      n_fail++;
    end
    @(posedge clk); #1;
    n_chk++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL basic_after: done=%b busy=%b required done=0 busy=0", done, busy);
      n_fail++;
    end
  endtask

  task automatic test_ties_zeros();
    frame_t t = '{32'h3F800000, 32'h40000000, 32'h40000000, 32'h80000000,
                  32'h00000000, 32'h40000000, 32'h3F800000};
    frame_t z = '{32'h80000000, 32'h00000000, 32'h80000000, 32'h00000000,
                  32'h00000000, 32'h80000000, 32'h00000000};
    run_frame("ties", t, 2);
    n_chk++;
    if (class_out !== 3'd1) begin
      $display("FAIL ties_const: class=%0d required 1", class_out);
      n_fail++;
    end
    run_frame("zeros", z, 2);
    n_chk++;
    if (class_out !== 3'd0 || max_out !== 32'h80000000) begin
      $display("FAIL zeros_const: class=%0d max=%h required class=0 max=80000000", class_out, max_out);
      n_fail++;
    end
  endtask

  task automatic test_neg_nan();
    frame_t s = '{32'h7FC00000, 32'hBF800000, 32'hC0000000, 32'hBF000000,
                  32'h7FC00000, 32'hC0400000, 32'hBF800000};
    run_frame("neg_nan", s, 1);
    n_chk++;
    if (class_out !== 3'd3 || max_out !== 32'hBF000000) begin
      $display("FAIL neg_nan_const: class=%0d max=%h required class=3 max=BF000000", class_out, max_out);
      n_fail++;
    end
  endtask

  task automatic test_back_to_back();
    frame_t f1, f2;
    for (int i = 0; i < 7; i++) begin
      f1[i] = 32'h3F800000 | 32'($urandom_range(32'h007FFFFF, 0));
      f2[i] = 32'hBF800000 | 32'($urandom_range(32'h007FFFFF, 0));
    end
    f1[6] = 32'h40800000;
    f2[0] = 32'h3E000000;
    run_frame("b2b_f1", f1, 5);
    run_frame("b2b_f2", f2, 0);
    n_chk++;
    if (class_out !== 3'd0 || max_out !== 32'h3E000000) begin
      $display("FAIL b2b_f2_const: class=%0d max=%h required class=0 max=3E000000", class_out, max_out);
      n_fail++;
    end
    run_frame("b2b_f3", f1, 0);
    n_chk++;
    if (class_out !== 3'd6) begin
      $display("FAIL b2b_f3_const: class=%0d required 6", class_out);
      n_fail++;
    end
  endtask

  task automatic test_random();
    frame_t s;
    logic [31:0] pool [8] = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000,
                              32'h7FC00000, 32'hFFFFFFFF, 32'h3F800000, 32'hBF800000};
    for (int f = 0; f < 30; f++) begin
      for (int i = 0; i < 7; i++)
        s[i] = ($urandom_range(2, 0) == 0) ? pool[$urandom_range(7, 0)] : 32'($urandom());
      if (f % 5 == 0) s[3] = s[1];
      run_frame("random", s, 3);
    end
  endtask

  task automatic test_reset_midframe();
    frame_t s = '{32'h3F800000, 32'h3F000000, 32'h40000000, 32'h3E800000,
                  32'h40000000, 32'h41200000, 32'hC1200000};
    for (int i = 0; i < 4; i++) begin
      valid_in = 1'b1; data_in = 32'h7F000000;
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; valid_in = 1'b0;
    exp_class = '0; exp_max = '0;
    n_chk++;
    if (class_out !== 3'd0 || max_out !== 32'd0 || done !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL rst_mid: class=%0d max=%h done=%b busy=%b required all zero",
               class_out, max_out, done, busy);
      n_fail++;
    end
    run_frame("after_rst", s, 2);
    n_chk++;
    if (class_out !== 3'd5 || max_out !== 32'h41200000) begin
      $display("FAIL after_rst_const: class=%0d max=%h required class=5 max=41200000", class_out, max_out);
      n_fail++;
    end
  endtask

`ifdef FC_ARGMAX_TIMEOUT_EN
  task automatic test_timeout();
    frame_t s = '{32'h3F800000, 32'h40E00000, 32'h3F000000, 32'h40000000,
                  32'h00000000, 32'h3F800000, 32'h3E000000};
    int n_err = 0;
    int n_done = 0;
    for (int i = 0; i < 3; i++) begin
      valid_in = 1'b1; data_in = 32'h7F000000;
      @(posedge clk); #1;
    end
    valid_in = 1'b0;
    for (int k = 0; k < 64; k++) begin
      @(posedge clk); #1;
      if (err === 1'b1) n_err++;
      if (done === 1'b1) n_done++;
    end
    n_chk++;
    if (n_err != 1 || err !== 1'b1 || n_done != 0 || busy !== 1'b0 ||
        class_out !== exp_class || max_out !== exp_max) begin
      $display("FAIL timeout: err_pulses=%0d err=%b done_pulses=%0d busy=%b class=%0d max=%h required 1 1 0 0 %0d %h",
               n_err, err, n_done, busy, class_out, max_out, exp_class, exp_max);
      n_fail++;
    end
    @(posedge clk); #1;
    n_chk++;
    if (err !== 1'b0) begin
      $display("FAIL timeout_pulse_width: err=%b required 0", err);
      n_fail++;
    end
    run_frame("after_timeout", s, 1);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_ties_zeros();
    test_neg_nan();
    test_back_to_back();
    test_random();
    test_reset_midframe();
`ifdef FC_ARGMAX_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
